// File: rtl/ysyx_24100029_pkg.sv
// Shared decode definitions for the ysyx_24100029 decode stage.
// Holds the RV32I opcode constants, ALU operation encodings, immediate
// format codes, the bit offsets of the packed control bundle, and helper
// functions for immediate extraction and ALU operation selection.
package ysyx_24100029_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6
  } imm_type_e;

  // Control bundle layout, LSB first; alu_op occupies [CTRL_ALU_OP +: 4].
  localparam int CTRL_ILLEGAL = 0;
  localparam int CTRL_CSR     = 1;
  localparam int CTRL_MRET    = 2;
  localparam int CTRL_ECALL   = 3;
  localparam int CTRL_JUMP    = 4;
  localparam int CTRL_BRANCH  = 5;
  localparam int CTRL_R_WEN   = 6;
  localparam int CTRL_MEM_REN = 7;
  localparam int CTRL_MEM_WEN = 8;
  localparam int CTRL_ALU_OP  = 9;
  localparam int CTRL_W       = 13;

  // 32-bit immediate; the caller sign-extends to XLEN (shamt has bit31=0).
  function automatic logic [31:0] imm32(input logic [31:0] i, input imm_type_e t);
    case (t)
      IMM_I:   imm32 = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm32 = {i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_SH:  imm32 = {27'b0, i[24:20]};
      default: imm32 = 32'b0;
    endcase
  endfunction

  // alt selects SUB/SRA; the caller masks it for immediate forms.
  function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24100029_decoder.sv
// Combinational RV32I instruction decoder.
// Ports: inst (32) in; imm (XLEN) sign-extended immediate; ctrl (CTRL_W)
// packed control bundle; uses_rs1/uses_rs2 flag which source fields the
// format actually reads (used for hazard detection).
module ysyx_24100029_decoder
  import ysyx_24100029_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32
) (
  input  logic [31:0]       inst,
  output logic [XLEN-1:0]   imm,
  output logic [CTRL_W-1:0] ctrl,
  output logic              uses_rs1,
  output logic              uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] f3;
  imm_type_e  imm_type;
  alu_op_e    alu_op;
  logic uses_rd, mem_wen, mem_ren, branch, jump, ecall, mret, csr, unknown;
  logic illegal, r_wen, small_rf;

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign small_rf = (NR_REGS == 16);

  always_comb begin
    imm_type = IMM_NONE;
    alu_op   = ALU_ADD;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    mem_wen  = 1'b0;
    mem_ren  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    ecall    = 1'b0;
    mret     = 1'b0;
    csr      = 1'b0;
    unknown  = 1'b0;
    case (opcode)
      OP_LUI:    begin imm_type = IMM_U; alu_op = ALU_PASS_B; uses_rd = 1'b1; end
      OP_AUIPC:  begin imm_type = IMM_U; uses_rd = 1'b1; end
      OP_JAL:    begin imm_type = IMM_J; jump = 1'b1; uses_rd = 1'b1; end
      OP_JALR:   begin imm_type = IMM_I; jump = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OP_BRANCH: begin
        imm_type = IMM_B; alu_op = ALU_SUB; branch = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_LOAD:   begin imm_type = IMM_I; mem_ren = 1'b1; uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OP_STORE:  begin imm_type = IMM_S; mem_wen = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_IMM: begin
        // Shifts carry a 5-bit shamt; inst[30] only means SRA for funct3=101.
        imm_type = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SH : IMM_I;
        alu_op   = alu_of(f3, inst[30] & (f3 == 3'b101));
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_REG: begin
        alu_op   = alu_of(f3, inst[30]);
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        if (f3 != 3'b000) begin
          // funct3[2] set means the zimm form: rs1 field is an immediate.
          csr      = 1'b1;
          imm_type = IMM_I;
          uses_rd  = 1'b1;
          uses_rs1 = ~f3[2];
        end else begin
          ecall = (inst == INST_ECALL);
          mret  = (inst == INST_MRET);
        end
      end
      default: unknown = 1'b1;
    endcase
  end

  // On RV32E any register field with bit 4 set names a nonexistent register.
  assign illegal = unknown
                 | (small_rf & uses_rd  & inst[11])
                 | (small_rf & uses_rs1 & inst[19])
                 | (small_rf & uses_rs2 & inst[24]);
  assign r_wen   = uses_rd & (inst[11:7] != 5'd0) & ~illegal;

  assign imm  = XLEN'($signed(imm32(inst, imm_type)));
  assign ctrl = {alu_op, mem_wen, mem_ren, r_wen, branch, jump, ecall, mret, csr, illegal};

endmodule

// File: rtl/ysyx_24100029_decode_stage.sv
// Decode pipeline stage between the IFU and EXU.
// Upstream: valid_last/ready_last handshake carrying inst and pc.
// Downstream: valid_next/ready_next handshake carrying pc_next, inst_next,
// register indices, funct3, imm and the packed ctrl_next bundle.
// Writeback: wb_valid/wb_rd release scoreboard entries.
// hazard flags that the held instruction waits on a busy source register.
// With SKID_EN=1 a second (skid) entry lets ready_last come from a flop.
module ysyx_24100029_decode_stage
  import ysyx_24100029_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32,
  parameter int SKID_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_last,
  output logic              ready_last,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  output logic              valid_next,
  input  logic              ready_next,
  output logic [XLEN-1:0]   pc_next,
  output logic [31:0]       inst_next,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd_next,
  output logic [2:0]        funct3,
  output logic [XLEN-1:0]   imm,
  output logic [CTRL_W-1:0] ctrl_next,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  output logic              hazard
);

  logic            out_valid_reg, skid_valid_reg;
  logic [31:0]     out_inst_reg, skid_inst_reg;
  logic [XLEN-1:0] out_pc_reg, skid_pc_reg;
  logic [31:0]     busy_reg, busy_next, busy_eff, set_vec, clr_vec;
  logic            uses_rs1, uses_rs2, accept, issue, out_free;

  ysyx_24100029_decoder #(.XLEN(XLEN), .NR_REGS(NR_REGS)) u_decoder (
    .inst     (out_inst_reg),
    .imm      (imm),
    .ctrl     (ctrl_next),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign inst_next = out_inst_reg;
  assign pc_next   = out_pc_reg;
  assign rs1       = out_inst_reg[19:15];
  assign rs2       = out_inst_reg[24:20];
  assign rd_next   = out_inst_reg[11:7];
  assign funct3    = out_inst_reg[14:12];

  assign hazard     = out_valid_reg & ((uses_rs1 & busy_eff[rs1]) | (uses_rs2 & busy_eff[rs2]));
  assign valid_next = out_valid_reg & ~hazard;
  assign issue      = valid_next & ready_next;
  assign out_free   = ~out_valid_reg | issue;
  assign accept     = valid_last & ready_last;

  generate
    if (SKID_EN != 0) begin : g_skid
      assign ready_last = ~skid_valid_reg;
    end else begin : g_noskid
      assign ready_last = out_free;
    end
  endgenerate

  // Per-register scoreboard set/clear; x0 and registers past NR_REGS never go busy.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0 || gi >= NR_REGS) begin : g_const
        assign set_vec[gi] = 1'b0;
        assign clr_vec[gi] = 1'b0;
      end else begin : g_live
        assign set_vec[gi] = issue & ctrl_next[CTRL_R_WEN] & (rd_next == 5'(gi));
        assign clr_vec[gi] = wb_valid & (wb_rd == 5'(gi));
      end
    end
  endgenerate

  // Same-cycle writeback unblocks; applying set after clear makes set win.
  assign busy_eff  = busy_reg & ~clr_vec;
  assign busy_next = busy_eff | set_vec;

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_reg  <= 1'b0;
      out_inst_reg   <= 32'b0;
      out_pc_reg     <= '0;
      skid_valid_reg <= 1'b0;
      skid_inst_reg  <= 32'b0;
      skid_pc_reg    <= '0;
      busy_reg       <= 32'b0;
    end else begin
      busy_reg <= busy_next;
      if (flush) begin
        out_valid_reg  <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (out_free) begin
        // The skid entry is older than anything on the input, so it goes first.
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_inst_reg   <= skid_inst_reg;
          out_pc_reg     <= skid_pc_reg;
          skid_valid_reg <= 1'b0;
        end else if (accept) begin
          out_valid_reg <= 1'b1;
          out_inst_reg  <= inst;
          out_pc_reg    <= pc;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept && SKID_EN != 0) begin
        skid_valid_reg <= 1'b1;
        skid_inst_reg  <= inst;
        skid_pc_reg    <= pc;
      end
    end
  end

endmodule

// File: doc/ysyx_24100029_decode_stage.md
YSYX_24100029_DECODE_STAGE -- requirements
Module: ysyx_24100029_decode_stage

Interface
REQ-001 SHALL take parameter XLEN, default 32: datapath width of pc, inst and imm.
REQ-002 SHALL take parameter NR_REGS, default 32: architectural register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL take parameter SKID_EN, default 1: 1 selects a registered ready_last with a skid entry; 0 selects a single stage with a combinational ready.
REQ-004 clock  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  synchronous, active-low.
REQ-006 flush  in  1  kill every held instruction (branch/trap redirect).
REQ-007 valid_last  in  1  upstream (IFU) offers inst/pc.
REQ-008 ready_last  out  1  stage can accept this cycle.
REQ-009 inst  in  32  fetched instruction.
REQ-010 pc  in  XLEN  fetched pc.
REQ-011 valid_next  out  1  decoded instruction offered to EXU.
REQ-012 ready_next  in  1  EXU accepts.
REQ-013 pc_next  out  XLEN  pc of the offered instruction.
REQ-014 inst_next  out  32  raw offered instruction.
REQ-015 rs1, rs2  out  5 each  source indices, driven to the external register file.
REQ-016 rd_next  out  5  destination index.
REQ-017 funct3  out  3  inst[14:12].
REQ-018 imm  out  XLEN  sign-extended immediate.
REQ-019 ctrl_next  out  CTRL_W  packed control bundle: alu_op[3:0], mem_wen, mem_ren, R_wen, branch, jump, ecall, mret, csr, illegal.
REQ-020 wb_valid  in  1  writeback retires a register write this cycle.
REQ-021 wb_rd  in  5  writeback destination index.
REQ-022 hazard  out  1  the held instruction is blocked by a RAW dependency.

Function
REQ-023 Handshake: transfer occurs on valid & ready at both ports; valid_next SHALL NOT depend combinationally on ready_next.
REQ-024 Holding: the output entry SHALL hold its contents while valid_next=1 and ready_next=0, or while hazard=1.
REQ-025 Skid (SKID_EN=1): ready_last = ~skid_valid, and it SHALL be registered.
REQ-026 Skid: an input accepted while the output entry is occupied and not leaving goes to the skid entry; the skid entry moves to output in the cycle the output empties.
REQ-027 No skid (SKID_EN=0): ready_last = ~out_valid | (ready_next & ~hazard).
REQ-028 Ordering: instructions SHALL leave in arrival order, with no loss or duplication.
REQ-029 Immediates: I/S/B/U/J formats per RV32I, sign-extended to XLEN; B and J immediates have bit0 = 0; shamt formats give zero-extended inst[24:20].
REQ-030 illegal SHALL be set for any unknown opcode, or for rs1/rs2/rd >= NR_REGS on a format that uses that field.
REQ-031 Other decoding: R_wen=0 for S, B and illegal instructions and when rd=0; ecall/mret are exact 32-bit matches.
REQ-032 Scoreboard: one busy bit per register; x0 is never busy.
REQ-033 Issue: on an issue (valid_next & ready_next) with R_wen=1, busy[rd_next] SHALL be set next cycle.
REQ-034 Writeback: wb_valid clears busy[wb_rd] next cycle.
REQ-035 Simultaneous set and clear of the same register: set wins.
REQ-036 hazard = out_valid & ((uses_rs1 & busy_eff[rs1]) | (uses_rs2 & busy_eff[rs2])), where busy_eff = busy & ~(wb_valid ? onehot(wb_rd) : 0), i.e. writeback in the same cycle unblocks.
REQ-037 valid_next = out_valid & ~hazard.
REQ-038 Flush clears out_valid and skid_valid next cycle, overriding any same-cycle accept.
REQ-039 Flush leaves busy bits untouched, because instructions already issued still write back.

Reset
REQ-040 On reset low at posedge, SHALL clear out_valid, skid_valid and all busy bits; outputs then read valid_next=0, hazard=0, ready_last=1, and inst/pc registers = 0 (so ctrl_next decodes inst=0, illegal=1).
REQ-041 Reset asserted mid-transfer SHALL discard both entries with no partial state.

Structure
REQ-042 Shared package ysyx_24100029_pkg SHALL hold the opcode constants, alu_op encodings, imm-type codes, and the CTRL_W field offsets.
REQ-043 Decoding SHALL be a combinational sub-module ysyx_24100029_decoder (inst -> imm, ctrl, uses_rs1/uses_rs2), instantiated once at the output entry.

Verification
REQ-044 Back-to-back addi x1,x0,5 then addi x2,x0,7 with ready_next=1 -> both issue on consecutive cycles, imm = 5, 7; busy[1] and busy[2] set.
REQ-045 add x3,x1,x2 with busy[1]=1 -> hazard=1, valid_next=0 until wb_valid=1 & wb_rd=1; issues in that same cycle.
REQ-046 ready_next=0 for 3 cycles while 3 inputs are offered -> with SKID_EN=1, 2 accepted and ready_last=0; order preserved after release.
REQ-047 flush in the same cycle as an accept with the skid entry full -> next cycle valid_next=0, ready_last=1, busy unchanged.
REQ-048 NR_REGS=16 with add x17,x1,x2 -> illegal=1, R_wen=0; beq with imm -4 -> imm=32'hFFFFFFFC.
REQ-049 Issue of rd=5 with wb_valid=1, wb_rd=5 in the same cycle -> busy[5]=1 afterwards.
